// File: rtl/eeprom_loader_if.sv
// -----------------------------------------------------------------------------
// eeprom_loader_if
//   Bundles the control handshake, ROM write port and SPI pins of the
//   EEPROM boot loader so they travel as one port.
//
//   start      loader input : one-cycle pulse requesting a load
//   busy       loader output: load in progress
//   done       loader output: one-cycle pulse after the last ROM write
//   rom_we     loader output: ROM write strobe (one cycle per byte)
//   rom_addr   loader output: ROM byte address, valid with rom_we
//   rom_wdata  loader output: ROM byte data, valid with rom_we
//   spi_cs     loader output: EEPROM chip select, active-low
//   spi_clk    loader output: SPI clock, mode 0 (idles low)
//   spi_do     loader output: MOSI
//   spi_di     loader input : MISO
//
//   master: the loader side.  slave: the side that starts the load and models
//   the EEPROM / ROM.
// -----------------------------------------------------------------------------
interface eeprom_loader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       rom_we;
  logic [9:0] rom_addr;
  logic [7:0] rom_wdata;
  logic       spi_cs;
  logic       spi_clk;
  logic       spi_do;
  logic       spi_di;

  modport master (
    input  start,
    input  spi_di,
    output busy,
    output done,
    output rom_we,
    output rom_addr,
    output rom_wdata,
    output spi_cs,
    output spi_clk,
    output spi_do
  );

  modport slave (
    output start,
    output spi_di,
    input  busy,
    input  done,
    input  rom_we,
    input  rom_addr,
    input  rom_wdata,
    input  spi_cs,
    input  spi_clk,
    input  spi_do
  );
endinterface

// File: rtl/eeprom_loader.sv
// -----------------------------------------------------------------------------
// eeprom_loader
//   Boot loader that copies BYTE_COUNT bytes from a serial SPI EEPROM into an
//   on-chip ROM. A single READ command (8'h03) plus a 16-bit start address is
//   sent once; the EEPROM then streams consecutive bytes while chip select is
//   held low, and each received byte is written to ROM at its 0-based index.
//
//   Parameters
//     CLOCK_DIV      raw_clk cycles per SPI clock half-period (2..255)
//     BYTE_COUNT     number of bytes to load (1..1024)
//     START_ADDRESS  first EEPROM byte address read
//
//   Ports
//     raw_clk  sole clock, all logic on its rising edge
//     reset    synchronous, active-high
//     bus      eeprom_loader_if.master: start/busy/done handshake,
//              ROM write port (rom_we/rom_addr/rom_wdata) and
//              SPI pins (spi_cs/spi_clk/spi_do/spi_di)
//
//   All outputs come straight from flops. SPI runs in mode 0: each bit is a
//   low half followed by a high half of CLOCK_DIV cycles each; MOSI is updated
//   on the edge that ends a high half (so it only moves while spi_clk is low)
//   and MISO is captured on the edge that raises spi_clk.
// -----------------------------------------------------------------------------
module eeprom_loader #(
  parameter int unsigned CLOCK_DIV     = 4,
  parameter int unsigned BYTE_COUNT    = 1024,
  parameter logic [15:0] START_ADDRESS = 16'h0000
) (
  input  logic            raw_clk,
  input  logic            reset,
  eeprom_loader_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CS_SETUP  = 3'd1;
  localparam logic [2:0] S_SEND_CMD  = 3'd2;
  localparam logic [2:0] S_SEND_ADDR = 3'd3;
  localparam logic [2:0] S_READ_BYTE = 3'd4;
  localparam logic [2:0] S_WRITE_ROM = 3'd5;
  localparam logic [2:0] S_CS_HOLD   = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [7:0]  CMD_READ = 8'h03;
  localparam logic [7:0]  DIV_LAST = 8'(CLOCK_DIV - 1);
  localparam logic [10:0] IDX_LAST = 11'(BYTE_COUNT - 1);

  // Control state
  logic [2:0]  state_q,     state_d;
  logic [7:0]  div_q,       div_d;      // position inside the current half-period
  logic [4:0]  bit_q,       bit_d;      // bit number within the current transfer phase
  logic [10:0] idx_q,       idx_d;      // ROM byte index, one spare bit above rom_addr
  logic        spi_cs_q,    spi_cs_d;
  logic        spi_clk_q,   spi_clk_d;
  logic        spi_do_q,    spi_do_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        rom_we_q,    rom_we_d;
  logic [9:0]  rom_addr_q,  rom_addr_d;
  logic [7:0]  rom_wdata_q, rom_wdata_d;

  // Shift registers (pure datapath, no reset needed)
  logic [23:0] tx_q, tx_d;              // command + address, MSB leaves first
  logic [7:0]  rx_q, rx_d;              // incoming byte, MSB arrives first

  logic div_end;
  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    spi_cs_d    = spi_cs_q;
    spi_clk_d   = spi_clk_q;
    spi_do_d    = spi_do_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    tx_d        = tx_q;
    rx_d        = rx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_CS_SETUP;
          spi_cs_d  = 1'b0;
          spi_clk_d = 1'b0;
          spi_do_d  = 1'b0;
          busy_d    = 1'b1;
          div_d     = 8'd0;
          bit_d     = 5'd0;
          idx_d     = 11'd0;
        end
      end

      // Chip select has just fallen; give the EEPROM CLOCK_DIV cycles of
      // setup with the clock parked low before the first bit.
      S_CS_SETUP: begin
        if (div_end) begin
          state_d  = S_SEND_CMD;
          div_d    = 8'd0;
          bit_d    = 5'd0;
          tx_d     = {CMD_READ, START_ADDRESS};
          spi_do_d = CMD_READ[7];
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // Shared bit engine. spi_clk_q doubles as the half-period flag:
      // low half ends by raising the clock (and sampling MISO), high half
      // ends by dropping the clock and presenting the next MOSI bit.
      S_SEND_CMD, S_SEND_ADDR, S_READ_BYTE: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end && !spi_clk_q) begin
          spi_clk_d = 1'b1;
          if (state_q == S_READ_BYTE) begin
            rx_d = {rx_q[6:0], bus.spi_di};
          end
        end else if (div_end) begin
          spi_clk_d = 1'b0;
          bit_d     = bit_q + 5'd1;
          tx_d      = {tx_q[22:0], 1'b0};
          spi_do_d  = tx_q[22];
          // bit_q runs 0..23 across command and address so the same counter
          // marks both phase boundaries.
          if (state_q == S_SEND_CMD && bit_q == 5'd7) begin
            state_d = S_SEND_ADDR;
          end else if (state_q == S_SEND_ADDR && bit_q == 5'd23) begin
            state_d  = S_READ_BYTE;
            bit_d    = 5'd0;
            spi_do_d = 1'b0;
          end else if (state_q == S_READ_BYTE) begin
            spi_do_d = 1'b0;
            if (bit_q == 5'd7) begin
              state_d     = S_WRITE_ROM;
              rom_we_d    = 1'b1;
              rom_addr_d  = idx_q[9:0];
              rom_wdata_d = rx_q;
            end
          end
        end
      end

      // rom_we is high for exactly this one cycle; the clock stays low and
      // chip select stays asserted so the EEPROM keeps streaming.
      S_WRITE_ROM: begin
        div_d   = 8'd0;
        bit_d   = 5'd0;
        idx_d   = idx_q + 11'd1;
        state_d = (idx_q == IDX_LAST) ? S_CS_HOLD : S_READ_BYTE;
      end

      S_CS_HOLD: begin
        if (div_end) begin
          state_d  = S_DONE;
          div_d    = 8'd0;
          spi_cs_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // start is deliberately not looked at here: a request arriving while
      // done is high is dropped, the next cycle in IDLE accepts one.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 5'd0;
      idx_q       <= 11'd0;
      spi_cs_q    <= 1'b1;
      spi_clk_q   <= 1'b0;
      spi_do_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= 10'd0;
      rom_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      spi_cs_q    <= spi_cs_d;
      spi_clk_q   <= spi_clk_d;
      spi_do_q    <= spi_do_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end

  always_ff @(posedge raw_clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.spi_cs    = spi_cs_q;
  assign bus.spi_clk   = spi_clk_q;
  assign bus.spi_do    = spi_do_q;

endmodule

// File: tb/tb_eeprom_loader.sv
// -----------------------------------------------------------------------------
// tb_eeprom_loader
//   Three loader instances share one clock:
//     g[0]  CLOCK_DIV=2, BYTE_COUNT=1024, START_ADDRESS=0, EEPROM byte a = a^5A
//     g[1]  CLOCK_DIV=4, BYTE_COUNT=3,    START_ADDRESS=0100, bytes A5,3C,FF
//     g[2]  CLOCK_DIV=2, BYTE_COUNT=16,   MISO tied high
//   Each instance has a behavioural SPI EEPROM (captures the 24 header bits,
//   then streams bytes from the captured address) and a ROM write recorder.
// -----------------------------------------------------------------------------
module tb_eeprom_loader;

  localparam int NK = 3;

  function automatic int cd_of(int k);
    case (k)
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int bc_of(int k);
    case (k)
      0:       return 1024;
      1:       return 3;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] sa_of(int k);
    case (k)
      1:       return 16'h0100;
      default: return 16'h0000;
    endcase
  endfunction

  // EEPROM contents per instance
  function automatic logic [7:0] eeprom_mem(int k, logic [15:0] a);
    if (k == 0) return a[7:0] ^ 8'h5A;
    if (k == 1) begin
      case (a)
        16'h0100: return 8'hA5;
        16'h0101: return 8'h3C;
        16'h0102: return 8'hFF;
        default:  return 8'h00;
      endcase
    end
    return 8'hFF;
  endfunction

  function automatic logic mem_bit(int k, logic [15:0] a, int n);
    logic [7:0] b;
    b = eeprom_mem(k, a);
    return b[n[2:0]];
  endfunction

  logic raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  int cyc = 0;
  always @(posedge raw_clk) cyc <= cyc + 1;

  logic [NK-1:0] rst_v;
  logic [NK-1:0] st_v;
  logic [NK-1:0] busy_v, done_v, cs_v, sclk_v;

  int tests = 0;
  int fails = 0;

  for (genvar k = 0; k < NK; k++) begin : g
    eeprom_loader_if bus ();

    eeprom_loader #(
      .CLOCK_DIV    (cd_of(k)),
      .BYTE_COUNT   (bc_of(k)),
      .START_ADDRESS(sa_of(k))
    ) dut (
      .raw_clk(raw_clk),
      .reset  (rst_v[k]),
      .bus    (bus)
    );

    logic        miso      = 1'b0;
    logic        sclk_prev = 1'b0;
    logic        do_prev   = 1'b0;
    int          hcnt      = 0;
    int          dcnt      = 0;
    logic [23:0] hdr       = 24'h0;
    int          rise_t [32];
    int          wn        = 0;
    int          dn        = 0;
    int          viol      = 0;
    logic [9:0]  wa [4096];
    logic [7:0]  wd [4096];

    assign bus.start = st_v[k];
    assign bus.spi_di = (k == 2) ? 1'b1 : miso;
    assign busy_v[k] = bus.busy;
    assign done_v[k] = bus.done;
    assign cs_v[k]   = bus.spi_cs;
    assign sclk_v[k] = bus.spi_clk;

    always @(posedge raw_clk) begin
      sclk_prev <= bus.spi_clk;
      do_prev   <= bus.spi_do;
      // MOSI may only move while the SPI clock is low
      if (bus.spi_clk === 1'b1 && bus.spi_do !== do_prev) viol <= viol + 1;
      if (bus.spi_cs !== 1'b0) begin
        hcnt <= 0;
        dcnt <= 0;
        miso <= 1'b0;
      end else begin
        if (!sclk_prev && bus.spi_clk && hcnt < 24) begin
          hdr              <= {hdr[22:0], bus.spi_do};
          rise_t[hcnt[4:0]] <= cyc;
          hcnt             <= hcnt + 1;
        end
        if (sclk_prev && !bus.spi_clk && hcnt == 24) begin
          miso <= mem_bit(k, hdr[15:0] + 16'(dcnt / 8), 7 - (dcnt % 8));
          dcnt <= dcnt + 1;
        end
      end
      if (bus.rom_we === 1'b1) begin
        if (wn < 4096) begin
          wa[wn[11:0]] <= bus.rom_addr;
          wd[wn[11:0]] <= bus.rom_wdata;
        end
        wn <= wn + 1;
      end
      if (bus.done === 1'b1) dn <= dn + 1;
    end
  end

  function automatic int get_wn(int k);
    case (k)
      0:       return g[0].wn;
      1:       return g[1].wn;
      default: return g[2].wn;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic pulse_start(int k);
    st_v[k] = 1'b1;
    @(negedge raw_clk);
    st_v[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge raw_clk);
      if (done_v[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_writes(int k, int target, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge raw_clk);
      if (get_wn(k) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int base;
    int dbase;
    int bad;
    int w0;

    rst_v = '1;
    st_v  = '0;
    tick(3);

    check("rst_cs",    32'(g[0].bus.spi_cs),    32'd1);
    check("rst_sclk",  32'(g[0].bus.spi_clk),   32'd0);
    check("rst_do",    32'(g[0].bus.spi_do),    32'd0);
    check("rst_busy",  32'(g[0].bus.busy),      32'd0);
    check("rst_done",  32'(g[0].bus.done),      32'd0);
    check("rst_we",    32'(g[0].bus.rom_we),    32'd0);
    check("rst_addr",  32'(g[0].bus.rom_addr),  32'd0);
    check("rst_wdata", 32'(g[0].bus.rom_wdata), 32'd0);

    rst_v = '0;
    tick(2);

    // ---- Short load, CLOCK_DIV=4, START_ADDRESS=0100 ----
    base  = g[1].wn;
    dbase = g[1].dn;
    pulse_start(1);
    check("t1_busy_after_start", 32'(busy_v[1]), 32'd1);
    check("t1_cs_after_start",   32'(cs_v[1]),    32'd0);
    check("t1_sclk_setup_low",   32'(sclk_v[1]),  32'd0);
    wait_done(1, 3000, ok);
    check("t1_done_seen",    32'(ok),        32'd1);
    check("t1_busy_at_done", 32'(busy_v[1]), 32'd0);
    check("t1_cs_at_done",   32'(cs_v[1]),   32'd1);
    // start presented during the done cycle must be dropped
    st_v[1] = 1'b1;
    tick(1);
    st_v[1] = 1'b0;
    check("t1_start_in_done_ignored", 32'(busy_v[1]), 32'd0);
    check("t1_cs_idle",  32'(cs_v[1]), 32'd1);
    check("t1_we_count", 32'(g[1].wn - base), 32'd3);
    check("t1_done_count", 32'(g[1].dn - dbase), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_addr%0d", i), 32'(g[1].wa[12'(base + i)]), 32'(i));
      check($sformatf("t1_data%0d", i), 32'(g[1].wd[12'(base + i)]),
            32'(eeprom_mem(1, 16'h0100 + 16'(i))));
    end
    check("t1_header", 32'(g[1].hdr), 32'h030100);
    check("t1_sclk_period", 32'(g[1].rise_t[1] - g[1].rise_t[0]), 32'd8);
    check("t1_sclk_period_addr", 32'(g[1].rise_t[13] - g[1].rise_t[12]), 32'd8);
    // the cycle right after the done cycle accepts a new start
    pulse_start(1);
    check("t1_restart_accepted", 32'(busy_v[1]), 32'd1);
    wait_done(1, 3000, ok);
    check("t1_second_done_seen", 32'(ok), 32'd1);
    tick(2);
    check("t1_second_we_count", 32'(g[1].wn - base), 32'd6);
    check("t1_second_first_addr", 32'(g[1].wa[12'(base + 3)]), 32'd0);
    check("t1_second_done_count", 32'(g[1].dn - dbase), 32'd2);

    // ---- Full 1024-byte load with a stray start at byte 10 ----
    base  = g[0].wn;
    dbase = g[0].dn;
    pulse_start(0);
    wait_writes(0, base + 10, 2000, ok);
    check("t2_reach_byte10", 32'(ok), 32'd1);
    pulse_start(0);
    check("t2_busy_mid", 32'(busy_v[0]), 32'd1);
    wait_done(0, 40000, ok);
    check("t2_done_seen", 32'(ok), 32'd1);
    tick(50);
    check("t2_we_count",   32'(g[0].wn - base),  32'd1024);
    check("t2_done_count", 32'(g[0].dn - dbase), 32'd1);
    check("t2_cs_high",    32'(cs_v[0]),   32'd1);
    check("t2_busy_low",   32'(busy_v[0]), 32'd0);
    check("t2_sclk_low",   32'(sclk_v[0]), 32'd0);
    check("t2_header",     32'(g[0].hdr),  32'h030000);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (g[0].wa[12'(base + i)] !== 10'(i) ||
          g[0].wd[12'(base + i)] !== eeprom_mem(0, 16'(i))) bad++;
    end
    check("t2_bad_bytes", 32'(bad), 32'd0);

    // ---- Reset at byte 500, then reload ----
    base  = g[0].wn;
    dbase = g[0].dn;
    pulse_start(0);
    wait_writes(0, base + 500, 20000, ok);
    check("t3_reach_byte500", 32'(ok), 32'd1);
    rst_v[0] = 1'b1;
    tick(1);
    check("t3_cs_after_reset",   32'(cs_v[0]),   32'd1);
    check("t3_busy_after_reset", 32'(busy_v[0]), 32'd0);
    tick(1);
    rst_v[0] = 1'b0;
    w0 = g[0].wn;
    tick(300);
    check("t3_writes_at_abort", 32'(w0 - base), 32'd500);
    check("t3_no_more_we",      32'(g[0].wn),   32'(w0));
    check("t3_no_done",         32'(g[0].dn),   32'(dbase));
    base = g[0].wn;
    pulse_start(0);
    wait_writes(0, base + 3, 500, ok);
    check("t3_reload_writes", 32'(ok), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_reload_addr%0d", i), 32'(g[0].wa[12'(base + i)]), 32'(i));
      check($sformatf("t3_reload_data%0d", i), 32'(g[0].wd[12'(base + i)]),
            32'(eeprom_mem(0, 16'(i))));
    end
    rst_v[0] = 1'b1;
    tick(2);
    rst_v[0] = 1'b0;

    // ---- CLOCK_DIV=2 with MISO stuck high ----
    base  = g[2].wn;
    dbase = g[2].dn;
    pulse_start(2);
    wait_done(2, 2000, ok);
    check("t4_done_seen", 32'(ok), 32'd1);
    tick(2);
    check("t4_we_count",   32'(g[2].wn - base),  32'd16);
    check("t4_done_count", 32'(g[2].dn - dbase), 32'd1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (g[2].wa[12'(base + i)] !== 10'(i) || g[2].wd[12'(base + i)] !== 8'hFF) bad++;
    end
    check("t4_bad_bytes", 32'(bad), 32'd0);

    check("mosi_stable_hi_0", 32'(g[0].viol), 32'd0);
    check("mosi_stable_hi_1", 32'(g[1].viol), 32'd0);
    check("mosi_stable_hi_2", 32'(g[2].viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eeprom_loader.md
EEPROM_LOADER -- requirements
Module: eeprom_loader

Interface
REQ-001 Parameter CLOCK_DIV, default 4, raw_clk cycles per SPI clock half-period (legal range 2..255).
REQ-002 Parameter BYTE_COUNT, default 1024, number of program bytes loaded into ROM (legal range 1..1024).
REQ-003 Parameter START_ADDRESS, default 16'h0000, first EEPROM byte address read.
REQ-004 raw_clk  input  1  sole clock; all logic on posedge raw_clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a load; ignored unless idle.
REQ-007 busy  output  1  high from the cycle after an accepted start until done asserts.
REQ-008 done  output  1  one-cycle pulse when the last byte has been written.
REQ-009 rom_we  output  1  ROM write strobe, one raw_clk cycle per byte.
REQ-010 rom_addr  output  10  ROM write address, valid while rom_we is high.
REQ-011 rom_wdata  output  8  ROM write data, valid while rom_we is high.
REQ-012 spi_cs  output  1  EEPROM chip select, active-low.
REQ-013 spi_clk  output  1  SPI clock, mode 0 (idle low).
REQ-014 spi_do  output  1  MOSI to the EEPROM.
REQ-015 spi_di  input  1  MISO from the EEPROM.

Function
REQ-016 States: IDLE, CS_SETUP, SEND_CMD, SEND_ADDR, READ_BYTE, WRITE_ROM, CS_HOLD, DONE.
REQ-017 IDLE -> CS_SETUP on start, which drops spi_cs low and raises busy on the next edge.
REQ-018 CS_SETUP shall last CLOCK_DIV cycles with spi_clk low, then go to SEND_CMD.
REQ-019 SEND_CMD shall shift out 8'h03 MSB first, then go to SEND_ADDR.
REQ-020 SEND_ADDR shall shift out the 16-bit START_ADDRESS MSB first, then go to READ_BYTE.
REQ-021 Bit timing: each bit occupies 2*CLOCK_DIV cycles, low half then high half.
REQ-022 spi_do shall change only while spi_clk is low.
REQ-023 spi_di shall be sampled on the raw_clk edge where spi_clk rises (low->high).
REQ-024 READ_BYTE shall shift in 8 bits MSB first, then go to WRITE_ROM with spi_clk low.
REQ-025 WRITE_ROM shall assert rom_we for exactly one cycle, with rom_addr equal to the byte index (0-based) and rom_wdata equal to the assembled byte.
REQ-026 After WRITE_ROM, the block shall return to READ_BYTE if index < BYTE_COUNT-1, otherwise go to CS_HOLD.
REQ-027 The byte index shall be 11 bits wide internally; rom_addr shall be its low 10 bits, and no wrap occurs within legal BYTE_COUNT.
REQ-028 Reads shall be continuous: spi_cs stays low and no command or address is resent between bytes.
REQ-029 The EEPROM address shall increment implicitly; the EEPROM address wrap at 16'hFFFF is the device's behaviour and is not modelled.
REQ-030 CS_HOLD shall keep spi_clk low for CLOCK_DIV cycles, then raise spi_cs and go to DONE.
REQ-031 DONE shall pulse done for one cycle, drop busy in that same cycle, and return to IDLE.
REQ-032 A start pulse arriving while not in IDLE shall be ignored, with no restart and no queuing.
REQ-033 A start pulse arriving in the same cycle DONE returns to IDLE shall be ignored; a start on the following cycle shall be accepted.
REQ-034 rom_we shall never assert outside WRITE_ROM.

Reset
REQ-035 reset has priority over every state transition and over start.
REQ-036 Reset values: state IDLE, spi_cs 1, spi_clk 0, spi_do 0, busy 0, done 0, rom_we 0, rom_addr 0, rom_wdata 0, byte index 0.
REQ-037 Reset mid-load shall abort the transfer: spi_cs rises on the next edge, no further rom_we is issued, and done does not pulse.

Verification
REQ-038 Default parameters, EEPROM model holding byte i = i[7:0] ^ 8'h5A, pulse start -> 1024 rom_we pulses, rom_addr 0..1023, data matches, exactly one done pulse, spi_cs high after done.
REQ-039 Check the bus -> first 24 MOSI bits are 8'h03 then 16'h0000, and with CLOCK_DIV=4 the spi_clk period is 8 raw_clk cycles.
REQ-040 BYTE_COUNT=3, START_ADDRESS=16'h0100, EEPROM data A5,3C,FF -> addr 0,1,2 receive A5,3C,FF and address bits on MOSI are 16'h0100.
REQ-041 Second start mid-load, at byte 10 -> ignored, and the transfer completes with the same byte count and a single done.
REQ-042 Reset asserted at byte 500 -> spi_cs=1 on the next cycle, no further rom_we, no done; a new start then reloads from rom_addr 0.
REQ-043 Start held for 1 cycle at CLOCK_DIV=2 with spi_di stuck at 1 -> every rom_wdata is 8'hFF and the load completes.
